// File: rtl/asi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : asi_pkg
//  Description : Shared AXI slave-interface widths for the user memory slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package asi_pkg;

    localparam int AXI_AW         = 32;
    localparam int AXI_DW         = 32;
    localparam int AXI_WSTRBW     = AXI_DW / 8;
    localparam int AXI_BYTES_LOG2 = $clog2(AXI_DW / 8);
    // Width of the word index carved out of a byte address.
    localparam int AXI_IDXW       = AXI_AW - AXI_BYTES_LOG2;

    // A word index addresses the memory only when it is below the depth.
    function automatic logic idx_in_range(input logic [AXI_IDXW-1:0] idx,
                                          input int unsigned depth);
        return ({1'b0, idx} < (AXI_IDXW + 1)'(depth));
    endfunction

endpackage : asi_pkg
`default_nettype wire

// File: rtl/asi_bram.sv
`default_nettype none
// ============================================================================
//  Module      : asi_bram
//  Description : Byte-enabled storage, one synchronous write port and one
//                asynchronous read port. FPGA_IP picks the RAM flavour.
//  Ports       : clk      - write clock
//                we_i     - write enable (already range-checked by caller)
//                wstrb_i  - per-byte lane enables
//                waddr_i  - write word index
//                wdata_i  - write data
//                raddr_i  - read word index
//                rdata_o  - read data, combinational from raddr_i
//  Revision    : 1.0 - initial release
// ============================================================================
module asi_bram
    import asi_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int FPGA_IP = 0
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AXI_WSTRBW-1:0] wstrb_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [AXI_DW-1:0]     wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [AXI_DW-1:0]     rdata_o
);

    // The asynchronous read port only fits LUT-based RAM, so the vendor
    // branches steer the same description onto MLAB / distributed RAM.
    if (FPGA_IP == 1) begin : g_altera
        (* ramstyle = "MLAB, no_rw_check" *) logic [AXI_DW-1:0] mem_q [DEPTH];
        always_ff @(posedge clk) begin
            for (int i = 0; i < AXI_WSTRBW; i++) begin
                if (we_i && wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        assign rdata_o = mem_q[raddr_i];
    end else if (FPGA_IP == 2) begin : g_xilinx
        (* ram_style = "distributed" *) logic [AXI_DW-1:0] mem_q [DEPTH];
        always_ff @(posedge clk) begin
            for (int i = 0; i < AXI_WSTRBW; i++) begin
                if (we_i && wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        assign rdata_o = mem_q[raddr_i];
    end else begin : g_infer
        logic [AXI_DW-1:0] mem_q [DEPTH];
        always_ff @(posedge clk) begin
            for (int i = 0; i < AXI_WSTRBW; i++) begin
                if (we_i && wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        assign rdata_o = mem_q[raddr_i];
    end

endmodule : asi_bram
`default_nettype wire

// File: rtl/asi_usr_mem.sv
`default_nettype none
// ============================================================================
//  Module      : asi_usr_mem
//  Description : User memory behind the AXI slave interface. Byte-strobed
//                writes, fixed-latency reads (SLV_WS wait states), sticky
//                out-of-range flags and a completed-write-burst counter.
//  Ports       : usr_clk/usr_reset        - clock, async active-high reset
//                m_waddr/m_wdata/m_wstrb  - write beat from asi_w
//                m_wlast/m_wvalid         - burst end / beat valid
//                m_raddr/m_re             - read request from asi_r
//                m_rdata/m_rvalid         - read response to asi_r
//                wr_oor/rd_oor            - sticky out-of-range flags
//                wr_burst_cnt             - completed write bursts, mod 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
module asi_usr_mem
    import asi_pkg::*;
#(
    parameter int MEM_D   = 1024,
    parameter int SLV_WS  = 2,
    parameter int FPGA_IP = 0
) (
    input  logic                  usr_clk,
    input  logic                  usr_reset,
    input  logic [AXI_AW-1:0]     m_waddr,
    input  logic [AXI_DW-1:0]     m_wdata,
    input  logic [AXI_WSTRBW-1:0] m_wstrb,
    input  logic                  m_wlast,
    input  logic                  m_wvalid,
    input  logic [AXI_AW-1:0]     m_raddr,
    input  logic                  m_re,
    output logic [AXI_DW-1:0]     m_rdata,
    output logic                  m_rvalid,
    output logic                  wr_oor,
    output logic                  rd_oor,
    output logic [15:0]           wr_burst_cnt
);

    localparam int MEM_AW = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    logic [AXI_IDXW-1:0] widx, ridx;
    logic                w_in_range, r_in_range;
    logic                bram_we;
    logic [AXI_DW-1:0]   bram_rdata, rd_word;
    logic                wr_oor_q, rd_oor_q;
    logic [15:0]         burst_cnt_q, burst_cnt_d;

    assign widx       = m_waddr[AXI_AW-1:AXI_BYTES_LOG2];
    assign ridx       = m_raddr[AXI_AW-1:AXI_BYTES_LOG2];
    assign w_in_range = idx_in_range(widx, MEM_D);
    assign r_in_range = idx_in_range(ridx, MEM_D);

    // Byte-offset bits carry no information for word-wide storage.
    logic unused_lsbs;
    assign unused_lsbs = ^{m_waddr[AXI_BYTES_LOG2-1:0], m_raddr[AXI_BYTES_LOG2-1:0]};

    // Gating with reset drops a beat coinciding with reset assertion.
    assign bram_we = m_wvalid & w_in_range & ~usr_reset;

    asi_bram #(
        .DEPTH   (MEM_D),
        .ADDR_W  (MEM_AW),
        .FPGA_IP (FPGA_IP)
    ) u_bram (
        .clk     (usr_clk),
        .we_i    (bram_we),
        .wstrb_i (m_wstrb),
        .waddr_i (widx[MEM_AW-1:0]),
        .wdata_i (m_wdata),
        .raddr_i (ridx[MEM_AW-1:0]),
        .rdata_o (bram_rdata)
    );

    // Out-of-range reads answer zeros so aliased words never leak out.
    assign rd_word = r_in_range ? bram_rdata : '0;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (m_wvalid && m_wlast) burst_cnt_d = burst_cnt_q + 16'd1;
    end

    always_ff @(posedge usr_clk or posedge usr_reset) begin
        if (usr_reset) begin
            wr_oor_q    <= 1'b0;
            rd_oor_q    <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            if (m_wvalid && !w_in_range) wr_oor_q <= 1'b1;
            if (m_re && !r_in_range)     rd_oor_q <= 1'b1;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign wr_oor       = wr_oor_q;
    assign rd_oor       = rd_oor_q;
    assign wr_burst_cnt = burst_cnt_q;

    if (SLV_WS == 0) begin : g_ws0
        // Zero wait states: pass-through read, with a hold register so the
        // bus keeps the last returned word while no read is presented.
        logic [AXI_DW-1:0] hold_q;
        always_ff @(posedge usr_clk or posedge usr_reset) begin
            if (usr_reset)  hold_q <= '0;
            else if (m_re)  hold_q <= rd_word;
        end
        assign m_rvalid = m_re;
        assign m_rdata  = m_re ? rd_word : hold_q;
    end else begin : g_wsn
        // Stage 0 samples the asynchronous read on the request edge, which
        // yields pre-write data for a same-edge read/write. Data stages load
        // only behind a valid, so the last stage holds between responses.
        logic [SLV_WS-1:0] vld_q;
        logic [AXI_DW-1:0] dat_q [SLV_WS];
        always_ff @(posedge usr_clk or posedge usr_reset) begin
            if (usr_reset) begin
                vld_q <= '0;
                for (int i = 0; i < SLV_WS; i++) dat_q[i] <= '0;
            end else begin
                vld_q[0] <= m_re;
                if (m_re) dat_q[0] <= rd_word;
                for (int i = 1; i < SLV_WS; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
            end
        end
        assign m_rvalid = vld_q[SLV_WS-1];
        assign m_rdata  = dat_q[SLV_WS-1];
    end

endmodule : asi_usr_mem
`default_nettype wire

// File: tb/tb_asi_usr_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asi_usr_mem
//  Description : Directed self-checking bench for asi_usr_mem
//                (AXI_DW=32, SLV_WS=2, MEM_D=1024).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asi_usr_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_waddr, m_wdata, m_raddr;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_re;
    logic [31:0] m_rdata;
    logic        m_rvalid, wr_oor, rd_oor;
    logic [15:0] wr_burst_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    asi_usr_mem #(
        .MEM_D   (1024),
        .SLV_WS  (2),
        .FPGA_IP (0)
    ) dut (
        .usr_clk      (clk),
        .usr_reset    (rst),
        .m_waddr      (m_waddr),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_wlast      (m_wlast),
        .m_wvalid     (m_wvalid),
        .m_raddr      (m_raddr),
        .m_re         (m_re),
        .m_rdata      (m_rdata),
        .m_rvalid     (m_rvalid),
        .wr_oor       (wr_oor),
        .rd_oor       (rd_oor),
        .wr_burst_cnt (wr_burst_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h want=%08h", tag, act, exp);
        end
    endtask

    // All tasks start and end 1 ns after a rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic l);
        m_waddr = a; m_wdata = d; m_wstrb = s; m_wlast = l; m_wvalid = 1'b1;
        @(posedge clk); #1;
        m_wvalid = 1'b0; m_wlast = 1'b0;
    endtask

    // Single read: no response one cycle after the request cycle, response
    // two cycles after it, then the bus must go idle and hold the word.
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        m_raddr = a; m_re = 1'b1;
        @(posedge clk); #1;
        m_re = 1'b0;
        chk({tag, "_early"}, {31'd0, m_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, {31'd0, m_rvalid}, 32'd1);
        chk({tag, "_dat"}, m_rdata, exp);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {31'd0, m_rvalid}, 32'd0);
        chk({tag, "_hold"}, m_rdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        m_waddr = '0; m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0;
        m_raddr = '0; m_re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", {31'd0, m_rvalid}, 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_wr_oor", {31'd0, wr_oor}, 32'd0);
        chk("rst_rd_oor", {31'd0, rd_oor}, 32'd0);
        chk("rst_cnt", {16'd0, wr_burst_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Strobed write: lanes 0 and 2 take the new bytes.
        wr(32'h10, 32'h11223344, 4'hF, 1'b1);
        wr(32'h10, 32'hAABBCCDD, 4'b0101, 1'b1);
        rd_chk("strobe", 32'h10, 32'h11BB33DD);
        chk("cnt_2", {16'd0, wr_burst_cnt}, 32'd2);

        // Fill words 0x00..0x1C, then read them back-to-back.
        for (int i = 0; i < 8; i++) wr(32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 1'b1);
        chk("cnt_10", {16'd0, wr_burst_cnt}, 32'd10);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 8) begin
                m_raddr = 32'(cyc * 4); m_re = 1'b1;
            end else begin
                m_re = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc >= 1 && cyc <= 8) begin
                chk($sformatf("b2b_vld%0d", cyc - 1), {31'd0, m_rvalid}, 32'd1);
                chk($sformatf("b2b_dat%0d", cyc - 1), m_rdata, 32'hA000_0000 + 32'(cyc - 1));
            end
        end
        chk("b2b_idle", {31'd0, m_rvalid}, 32'd0);

        // Same-edge read and write to one word return the old contents.
        wr(32'h20, 32'h0, 4'hF, 1'b1);
        m_waddr = 32'h20; m_wdata = 32'hFFFF_FFFF; m_wstrb = 4'hF; m_wlast = 1'b0;
        m_wvalid = 1'b1; m_raddr = 32'h20; m_re = 1'b1;
        @(posedge clk); #1;
        m_wvalid = 1'b0; m_re = 1'b0;
        @(posedge clk); #1;
        chk("rw_vld", {31'd0, m_rvalid}, 32'd1);
        chk("rw_old", m_rdata, 32'h0);
        @(posedge clk); #1;
        rd_chk("rw_new", 32'h20, 32'hFFFF_FFFF);
        chk("cnt_11", {16'd0, wr_burst_cnt}, 32'd11);

        // Out-of-range: index 0x400 aliases word 0 in the low bits.
        wr(32'h1000, 32'hDEAD_BEEF, 4'hF, 1'b1);
        chk("oor_wr_flag", {31'd0, wr_oor}, 32'd1);
        chk("oor_rd_flag0", {31'd0, rd_oor}, 32'd0);
        rd_chk("oor_rd", 32'h1000, 32'h0);
        chk("oor_rd_flag1", {31'd0, rd_oor}, 32'd1);
        rd_chk("oor_word0", 32'h0, 32'hA000_0000);
        chk("cnt_12", {16'd0, wr_burst_cnt}, 32'd12);

        // Preload the counter to 0xFFFF with out-of-range last beats.
        m_waddr = 32'h1000; m_wdata = 32'h0; m_wstrb = 4'hF; m_wlast = 1'b1; m_wvalid = 1'b1;
        repeat (16'hFFFF - 16'd12) @(posedge clk);
        #1;
        m_wvalid = 1'b0;
        chk("cnt_ffff", {16'd0, wr_burst_cnt}, 32'h0000_FFFF);
        @(posedge clk); #1;
        m_wlast = 1'b0;
        chk("cnt_no_vld", {16'd0, wr_burst_cnt}, 32'h0000_FFFF);
        wr(32'h1000, 32'h0, 4'hF, 1'b1);
        chk("cnt_wrap", {16'd0, wr_burst_cnt}, 32'h0);
        chk("wr_oor_sticky", {31'd0, wr_oor}, 32'd1);

        // Read in flight killed by reset; write on the reset edge dropped.
        wr(32'h24, 32'h1234_5678, 4'hF, 1'b1);
        m_raddr = 32'h10; m_re = 1'b1;
        @(posedge clk); #1;
        m_re = 1'b0;
        rst = 1'b1;
        m_waddr = 32'h24; m_wdata = 32'h5555_5555; m_wstrb = 4'hF; m_wvalid = 1'b1;
        #1;
        chk("rst_async_vld", {31'd0, m_rvalid}, 32'd0);
        chk("rst_async_dat", m_rdata, 32'h0);
        @(posedge clk); #1;
        m_wvalid = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_no_vld%0d", k), {31'd0, m_rvalid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rst_rdata2", m_rdata, 32'h0);
        chk("rst_wr_oor2", {31'd0, wr_oor}, 32'd0);
        chk("rst_rd_oor2", {31'd0, rd_oor}, 32'd0);
        chk("rst_cnt2", {16'd0, wr_burst_cnt}, 32'd0);
        rd_chk("rst_wr_drop", 32'h24, 32'h1234_5678);
        rd_chk("mem_kept", 32'h1C, 32'hA000_0007);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_asi_usr_mem
`default_nettype wire
